// File: rtl/ctu_tsr_sar_ctl.sv
// Successive-approximation controller for the on-die temperature sensor:
// drives DAC trial codes, resolves a WIDTH-bit code and raises a hysteretic alarm.
module ctu_tsr_sar_ctl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4,
    parameter int HYST   = 4
) (
    input  logic             jbus_clk,
    input  logic             jbus_rst,
    input  logic             start,
    input  logic             cont_en,
    input  logic             tsr_cmp,
    input  logic [WIDTH-1:0] alarm_thr,
    output logic [WIDTH-1:0] tsr_dac,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] temp_code,
    output logic             temp_vld,
    output logic             alarm
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MSB_TRIAL   = WIDTH'(1) << (WIDTH - 1);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [WIDTH:0]   HYST_W      = (WIDTH + 1)'(HYST);

    state_t           state_q, state_d;
    logic             cmp_meta_q, cmp_s_q;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic             vld_q, vld_d;
    logic             alarm_q, alarm_d;
    logic [WIDTH-1:0] resolved;
    logic [WIDTH:0]   code_ext, thr_ext;

    always_ff @(posedge jbus_clk) begin
        if (jbus_rst) begin
            state_q    <= ST_IDLE;
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
            cnt_q      <= '0;
            mask_q     <= '0;
            dac_q      <= '0;
            code_q     <= '0;
            vld_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmp_meta_q <= tsr_cmp;
            cmp_s_q    <= cmp_meta_q;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            dac_q      <= dac_d;
            code_q     <= code_d;
            vld_q      <= vld_d;
            alarm_q    <= alarm_d;
        end
    end

    // Current trial bit kept when the sensor is at or above the DAC, dropped otherwise.
    assign resolved = cmp_s_q ? dac_q : (dac_q & ~mask_q);
    assign code_ext = {1'b0, resolved};
    assign thr_ext  = {1'b0, alarm_thr};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dac_d   = dac_q;
        code_d  = code_q;
        vld_d   = vld_q;
        alarm_d = alarm_q;

        case (state_q)
            ST_IDLE: begin
                dac_d = '0;
                if (start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    mask_d  = MSB_TRIAL;
                    dac_d   = MSB_TRIAL;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DECIDE;
                    cnt_d   = '0;
                end
            end
            ST_DECIDE: begin
                if (mask_q[0]) begin
                    // Result and alarm are latched on entry to DONE so that they
                    // are already valid during the cycle in which done is high.
                    state_d = ST_DONE;
                    dac_d   = resolved;
                    code_d  = resolved;
                    vld_d   = 1'b1;
                    if (code_ext >= thr_ext) begin
                        alarm_d = 1'b1;
                    end else if ((code_ext + HYST_W) < thr_ext) begin
                        alarm_d = 1'b0;
                    end
                end else begin
                    state_d = ST_SETTLE;
                    mask_d  = mask_q >> 1;
                    dac_d   = resolved | (mask_q >> 1);
                end
            end
            ST_DONE: begin
                if (cont_en) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    mask_d  = MSB_TRIAL;
                    dac_d   = MSB_TRIAL;
                end else begin
                    state_d = ST_IDLE;
                    dac_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dac_d   = '0;
            end
        endcase
    end

    assign tsr_dac   = dac_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign temp_code = code_q;
    assign temp_vld  = vld_q;
    assign alarm     = alarm_q;

endmodule

// File: doc/ctu_tsr_sar_ctl.md
Name: ctu_tsr_sar_ctl

Overview:
Successive-approximation controller for the on-die temperature sensor brought out through the CTU pad cluster's tsr_testio path. It drives the sensor DAC trial code, samples the asynchronous comparator through a synchroniser and resolves a WIDTH-bit temperature code. It also raises an over-temperature alarm with hysteresis. It sits in the CTU on the jbus clock, directly downstream of the pad cluster's sensor I/O.

Parameters:
WIDTH, 8, bits of DAC and temperature code.
SETTLE, 4, settle cycles per bit before the comparator is sampled. Legal range 3..255.
HYST, 4, alarm clear hysteresis in code LSBs. Must be less than 2^WIDTH.

Ports:
jbus_clk  input  1  sole clock; all state is updated on its rising edge.
jbus_rst  input  1  reset, synchronous and active-high.
start  input  1  one-cycle conversion request; honoured only in IDLE.
cont_en  input  1  continuous mode: each conversion restarts from DONE.
tsr_cmp  input  1  asynchronous sensor comparator; 1 means sensor >= DAC.
alarm_thr  input  WIDTH  alarm threshold code.
tsr_dac  output  WIDTH  DAC trial code driven to the sensor.
busy  output  1  high in SETTLE, DECIDE and DONE.
done  output  1  one-cycle pulse when temp_code updates.
temp_code  output  WIDTH  last completed conversion result.
temp_vld  output  1  set by the first completed conversion since reset.
alarm  output  1  over-temperature flag.

Behaviour:
- Reset (synchronous, jbus_rst=1 at an edge):
  - all outputs go to 0, FSM goes to IDLE, synchroniser flops go to 0.
  - This applies at any point, including mid-conversion; the partial result is discarded.
- tsr_cmp passes through a 2-flop synchroniser. Only the second flop's output (cmp_s) is ever used.
- FSM states: IDLE, SETTLE, DECIDE, DONE.
- IDLE:
  - tsr_dac=0, busy=0.
  - start=1 -> SETTLE. Bit index = WIDTH-1, result register cleared, tsr_dac = MSB trial (1 << (WIDTH-1)), settle counter = 0.
- SETTLE:
  - Counter increments each cycle.
  - After exactly SETTLE cycles in SETTLE -> DECIDE.
- DECIDE (1 cycle):
  - Sample cmp_s. If cmp_s=1, keep the trial bit; otherwise clear it.
  - If bit index > 0: decrement the index, set the next lower trial bit in tsr_dac, -> SETTLE.
  - If bit index = 0 -> DONE.
- DONE (1 cycle):
  - temp_code <= resolved code, temp_vld <= 1, done=1, alarm updated, tsr_dac holds the final code.
  - If cont_en=1, go to SETTLE with a new MSB trial. Otherwise go to IDLE.
- Each bit takes SETTLE+1 cycles.
  - With start seen at cycle 0, done is high at cycle 1 + WIDTH*(SETTLE+1). This is 41 for the defaults.
  - In continuous mode, done pulses have a period of 1 + WIDTH*(SETTLE+1).
- start while busy=1 is ignored, with no queuing.
- Deasserting cont_en mid-conversion lets the current conversion finish, then the FSM returns to IDLE.
- Alarm, evaluated only in the DONE cycle on the new code (WIDTH+1-bit compare, no wrap):
  - Set if code >= alarm_thr.
  - Else cleared if code + HYST < alarm_thr.
  - Else held.
- alarm_thr is sampled only in DONE; it may change at any time.
- temp_code and alarm are stable between done pulses.

Test Plan:
- Comparator tied 1, start at cycle 0 -> tsr_dac steps 0x80, 0xC0, ... 0xFF; done at cycle 41 with temp_code=0xFF, temp_vld=1. Tied 0 -> temp_code=0x00.
- Comparator model cmp = (0x5A >= tsr_dac) with 2-cycle delay, start -> done at cycle 41, temp_code=0x5A, busy low from cycle 42.
- alarm_thr=0x80, successive conversions with sensor 0x80 -> alarm=1; then 0x7D -> alarm stays 1; then 0x7B -> alarm=0; then 0x7F -> alarm stays 0.
- cont_en=1 with a single start -> done pulses at cycles 41, 82, 123. cont_en dropped at cycle 60 -> last done at 82, then IDLE, tsr_dac=0.
- jbus_rst at cycle 20 of a conversion -> next cycle all outputs 0, FSM in IDLE; start at cycle 22 -> done at cycle 63.
- start pulsed at cycles 10 and 30 during a conversion -> ignored; exactly one done per conversion.
